// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: data width,
// operation encodings and FSM state encoding.
package mul_div_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Radix-2 iterative multiply/divide unit (MULT/MULTU/DIV/DIVU), 32 iterations
// per operation, results held in hi/lo until the next completion.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startValid,
  output logic             startReady,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             doneValid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   opb_q;
  logic               neg_q_q;
  logic               neg_r_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               dbz_q;

  // Operand capture: magnitudes plus signs for the signed operations
  logic             signed_op;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    signed_op = op_is_signed(op_e'(op));
    sign_a    = signed_op & operandA[WIDTH-1];
    sign_b    = signed_op & operandB[WIDTH-1];
    abs_a     = sign_a ? -operandA : operandA;
    abs_b     = sign_b ? -operandB : operandB;
  end

  // One iteration. acc_q/work_q are shared: product high/low for multiply,
  // partial remainder and dividend-in/quotient-out for divide.
  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   rsh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] work_n;

  always_comb begin
    madd = {1'b0, acc_q} + (work_q[0] ? {1'b0, opb_q} : '0);
    rsh  = {acc_q, work_q[WIDTH-1]};
    ge   = (rsh >= {1'b0, opb_q});
    diff = rsh - {1'b0, opb_q};
    if (is_div_q) begin
      acc_n  = WIDTH'(ge ? diff : rsh);
      work_n = {work_q[WIDTH-2:0], ge};
    end else begin
      acc_n  = madd[WIDTH:1];
      work_n = {madd[0], work_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied to the final iteration's outputs
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic               dbz_d;

  always_comb begin
    prod     = {acc_n, work_n};
    prod_fix = neg_q_q ? -prod : prod;
    quo_fix  = neg_q_q ? -work_n : work_n;
    rem_fix  = neg_r_q ? -acc_n : acc_n;
    if (is_div_q) begin
      // A zero divisor leaves |A| in the remainder; re-signing it restores A.
      dbz_d = (opb_q == '0);
      lo_d  = dbz_d ? '1 : quo_fix;
      hi_d  = rem_fix;
    end else begin
      dbz_d = 1'b0;
      lo_d  = prod_fix[WIDTH-1:0];
      hi_d  = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      work_q   <= '0;
      opb_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startValid) begin
            is_div_q <= op_is_div(op_e'(op));
            acc_q    <= '0;
            work_q   <= abs_a;
            opb_q    <= abs_b;
            neg_q_q  <= sign_a ^ sign_b;
            neg_r_q  <= sign_a;
            cnt_q    <= CNT_W'(WIDTH - 1);
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q  <= acc_n;
          work_q <= work_n;
          if (cnt_q == '0) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign startReady = (state_q == IDLE);
  assign busy       = (state_q == BUSY);
  assign doneValid  = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign divByZero  = dbz_q;

endmodule
